// File: rtl/mc14500b_seq.sv
// Program sequencer for an MC14500B ICU: fetches ROM words, issues them, and handles jumps/calls/returns.
// Optional halt-on-NOPF support is compiled in with the MC14500B_SEQ_HALT_EN macro.
module mc14500b_seq (
    input  logic       clk_in,
    input  logic       rst,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [3:0] I,
    output logic [3:0] io_addr,
    output logic       instr_valid,
    input  logic       step,
    input  logic       JMP,
    input  logic       RTN,
    input  logic       SKP,
    input  logic       FLGF,
    output logic       halted,
    output logic       stack_err
);

    typedef enum logic [2:0] {
        FETCH,
        LATCH,
        ISSUE,
        TFETCH,
        TLATCH
`ifdef MC14500B_SEQ_HALT_EN
        , HALT
`endif
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic [7:0] pc_next;
    logic [7:0] pc_inc;
    logic [2:0] sp;
    logic [1:0] top_idx;
    logic [7:0] stack [4];
    logic       push_en;
    logic       pop_en;
    logic       latch_en;

    assign pc_inc  = pc + 8'd1;
    assign top_idx = 2'(sp - 3'd1);

    // The jump path reads the target byte that follows the jump instruction.
    assign rom_addr    = (state == TFETCH || state == TLATCH) ? pc_inc : pc;
    assign instr_valid = (state == ISSUE);

`ifdef MC14500B_SEQ_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push_en    = 1'b0;
        pop_en     = 1'b0;
        latch_en   = 1'b0;
        case (state)
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                latch_en   = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (step) begin
                    if (SKP) begin
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end else if (RTN) begin
                        pop_en     = 1'b1;
                        pc_next    = (sp == 3'd0) ? 8'h00 : stack[top_idx];
                        state_next = FETCH;
                    end else if (JMP) begin
                        state_next = TFETCH;
`ifdef MC14500B_SEQ_HALT_EN
                    end else if (FLGF) begin
                        state_next = HALT;
`else
                    end else if (FLGF) begin
                        pc_next    = pc_inc;
                        state_next = FETCH;
`endif
                    end else begin
                        pc_next    = pc_inc;
                        state_next = FETCH;
                    end
                end
            end
            TFETCH: begin
                state_next = TLATCH;
            end
            TLATCH: begin
                // A call is flagged by bit 3 of the jump instruction's I/O field.
                push_en    = io_addr[3];
                pc_next    = rom_data;
                state_next = FETCH;
            end
`ifdef MC14500B_SEQ_HALT_EN
            HALT: begin
                state_next = HALT;
            end
`endif
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= FETCH;
            pc    <= 8'h00;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            I         <= 4'b0000;
            io_addr   <= 4'h0;
            sp        <= 3'd0;
            stack_err <= 1'b0;
        end else begin
            if (latch_en) begin
                I       <= rom_data[7:4];
                io_addr <= rom_data[3:0];
            end
            // Overflowing pushes are dropped; the jump itself still proceeds.
            if (push_en) begin
                if (sp == 3'd4) begin
                    stack_err <= 1'b1;
                end else begin
                    stack[sp[1:0]] <= pc_inc;
                    sp             <= sp + 3'd1;
                end
            end
            if (pop_en) begin
                if (sp == 3'd0) begin
                    stack_err <= 1'b1;
                end else begin
                    sp <= sp - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc14500b_seq.sv
// Directed testbench for mc14500b_seq: the bench plays the ROM and the ICU.
// Halt scenarios follow the MC14500B_SEQ_HALT_EN build setting.
module tb_mc14500b_seq;

    logic       clk_in;
    logic       rst;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] I;
    logic [3:0] io_addr;
    logic       instr_valid;
    logic       step;
    logic       JMP;
    logic       RTN;
    logic       SKP;
    logic       FLGF;
    logic       halted;
    logic       stack_err;

    logic [7:0] rom [256];
    int checks = 0;
    int errors = 0;

    mc14500b_seq dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .I          (I),
        .io_addr    (io_addr),
        .instr_valid(instr_valid),
        .step       (step),
        .JMP        (JMP),
        .RTN        (RTN),
        .SKP        (SKP),
        .FLGF       (FLGF),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) rom_data <= rom[rom_addr];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_valid(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_in);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got no instr_valid expected instr_valid=1 within 16 cycles", name);
        end
    endtask

    task automatic pulse_step(input logic skp, input logic rtn, input logic jmp, input logic flgf);
        step = 1'b1; SKP = skp; RTN = rtn; JMP = jmp; FLGF = flgf;
        @(negedge clk_in);
        step = 1'b0; SKP = 1'b0; RTN = 1'b0; JMP = 1'b0; FLGF = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk_in);
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_rom_addr: got %h expected %h", rom_addr, 8'h00); end
        checks++; if (I !== 4'h0) begin errors++; $display("[TB] FAIL reset_I: got %h expected %h", I, 4'h0); end
        checks++; if (io_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_io_addr: got %h expected %h", io_addr, 4'h0); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected %b", instr_valid, 1'b0); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected %b", halted, 1'b0); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_stack_err: got %b expected %b", stack_err, 1'b0); end
    endtask

    task automatic test_fetch_issue();
        rst = 1'b0;
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL first_fetch: got %h expected %h", rom_addr, 8'h00); end
        @(negedge clk_in);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL latency_early: got %b expected %b", instr_valid, 1'b0); end
        @(negedge clk_in);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL latency_two: got %b expected %b", instr_valid, 1'b1); end
        checks++; if ({I, io_addr} !== 8'h1A) begin errors++; $display("[TB] FAIL issue0: got %h expected %h", {I, io_addr}, 8'h1A); end
        pulse_step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rom_addr !== 8'h01) begin errors++; $display("[TB] FAIL fetch1: got %h expected %h", rom_addr, 8'h01); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL valid_drop: got %b expected %b", instr_valid, 1'b0); end
        // A stray step during fetch must not advance the PC.
        step = 1'b1;
        @(negedge clk_in);
        step = 1'b0;
        wait_valid("wait_issue1");
        checks++; if ({I, io_addr} !== 8'h51) begin errors++; $display("[TB] FAIL issue1: got %h expected %h", {I, io_addr}, 8'h51); end
        checks++; if (rom_addr !== 8'h01) begin errors++; $display("[TB] FAIL stray_step: got %h expected %h", rom_addr, 8'h01); end
        pulse_step(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (rom_addr !== 8'h02) begin errors++; $display("[TB] FAIL fetch2: got %h expected %h", rom_addr, 8'h02); end
        wait_valid("wait_issue2");
        checks++; if ({I, io_addr} !== 8'hC0) begin errors++; $display("[TB] FAIL issue2: got %h expected %h", {I, io_addr}, 8'hC0); end
        pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (rom_addr !== 8'h03) begin errors++; $display("[TB] FAIL jump_tfetch: got %h expected %h", rom_addr, 8'h03); end
        repeat (2) @(negedge clk_in);
        checks++; if (rom_addr !== 8'h10) begin errors++; $display("[TB] FAIL jump_target: got %h expected %h", rom_addr, 8'h10); end
        checks++; if (dut.sp !== 3'd0) begin errors++; $display("[TB] FAIL jump_no_push: got %0d expected %0d", dut.sp, 0); end
    endtask

    task automatic test_call_return();
        wait_valid("wait_call");
        checks++; if ({I, io_addr} !== 8'hC8) begin errors++; $display("[TB] FAIL call_instr: got %h expected %h", {I, io_addr}, 8'hC8); end
        pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (rom_addr !== 8'h11) begin errors++; $display("[TB] FAIL call_tfetch: got %h expected %h", rom_addr, 8'h11); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL call_tfetch_valid: got %b expected %b", instr_valid, 1'b0); end
        @(negedge clk_in);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL call_tlatch_valid: got %b expected %b", instr_valid, 1'b0); end
        @(negedge clk_in);
        checks++; if (rom_addr !== 8'h40) begin errors++; $display("[TB] FAIL call_target: got %h expected %h", rom_addr, 8'h40); end
        wait_valid("wait_target");
        checks++; if ({I, io_addr} !== 8'h21) begin errors++; $display("[TB] FAIL target_instr: got %h expected %h", {I, io_addr}, 8'h21); end
        checks++; if (dut.sp !== 3'd1) begin errors++; $display("[TB] FAIL call_sp: got %0d expected %0d", dut.sp, 1); end
        checks++; if (dut.stack[0] !== 8'h11) begin errors++; $display("[TB] FAIL call_stack0: got %h expected %h", dut.stack[0], 8'h11); end
        pulse_step(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (rom_addr !== 8'h11) begin errors++; $display("[TB] FAIL return_addr: got %h expected %h", rom_addr, 8'h11); end
        wait_valid("wait_ret");
        checks++; if ({I, io_addr} !== 8'h40) begin errors++; $display("[TB] FAIL ret_issue: got %h expected %h", {I, io_addr}, 8'h40); end
        // SKP outranks every other flag, including a simultaneous jump or return.
        pulse_step(1'b1, 1'b1, 1'b1, 1'b1);
        checks++; if (rom_addr !== 8'h12) begin errors++; $display("[TB] FAIL skip_addr: got %h expected %h", rom_addr, 8'h12); end
        @(negedge clk_in);
        checks++; if (rom_addr !== 8'h12) begin errors++; $display("[TB] FAIL skip_no_jump: got %h expected %h", rom_addr, 8'h12); end
        checks++; if (dut.sp !== 3'd0) begin errors++; $display("[TB] FAIL skip_no_pop: got %0d expected %0d", dut.sp, 0); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("[TB] FAIL skip_stack_err: got %b expected %b", stack_err, 1'b0); end
    endtask

    task automatic test_nested_calls();
        logic [7:0] targets [5];
        logic [7:0] returns [5];
        targets = '{8'h20, 8'h30, 8'h50, 8'h60, 8'h70};
        returns = '{8'h51, 8'h31, 8'h21, 8'h13, 8'h00};
        for (int k = 0; k < 5; k++) begin
            wait_valid("wait_nest");
            pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (2) @(negedge clk_in);
            checks++; if (rom_addr !== targets[k]) begin errors++; $display("[TB] FAIL nest_target%0d: got %h expected %h", k, rom_addr, targets[k]); end
            checks++; if (stack_err !== (k == 4)) begin errors++; $display("[TB] FAIL nest_err%0d: got %b expected %b", k, stack_err, (k == 4)); end
        end
        checks++; if (dut.sp !== 3'd4) begin errors++; $display("[TB] FAIL nest_sp: got %0d expected %0d", dut.sp, 4); end
        for (int k = 0; k < 5; k++) begin
            wait_valid("wait_pop");
            pulse_step(1'b0, 1'b1, 1'b0, 1'b0);
            checks++; if (rom_addr !== returns[k]) begin errors++; $display("[TB] FAIL pop%0d: got %h expected %h", k, rom_addr, returns[k]); end
        end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("[TB] FAIL underflow_err: got %b expected %b", stack_err, 1'b1); end
        checks++; if (dut.sp !== 3'd0) begin errors++; $display("[TB] FAIL underflow_sp: got %0d expected %0d", dut.sp, 0); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        @(negedge clk_in);
        checks++; if (stack_err !== 1'b0) begin errors++; $display("[TB] FAIL err_clear: got %b expected %b", stack_err, 1'b0); end
        rst = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            wait_valid("wait_w0");
            pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
            repeat (2) @(negedge clk_in);
            wait_valid("wait_w1");
            pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
            checks++; if (rom_addr !== 8'h52) begin errors++; $display("[TB] FAIL wrap_tfetch%0d: got %h expected %h", pass, rom_addr, 8'h52); end
            repeat (2) @(negedge clk_in);
            checks++; if (rom_addr !== 8'hFF) begin errors++; $display("[TB] FAIL reach_ff%0d: got %h expected %h", pass, rom_addr, 8'hFF); end
            wait_valid("wait_ff");
            checks++; if ({I, io_addr} !== 8'h7E) begin errors++; $display("[TB] FAIL ff_instr%0d: got %h expected %h", pass, {I, io_addr}, 8'h7E); end
            if (pass == 0) begin
                pulse_step(1'b0, 1'b0, 1'b0, 1'b0);
                checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL pc_wrap: got %h expected %h", rom_addr, 8'h00); end
            end
        end
        pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL tfetch_wrap: got %h expected %h", rom_addr, 8'h00); end
        repeat (2) @(negedge clk_in);
        checks++; if (rom_addr !== 8'h1A) begin errors++; $display("[TB] FAIL wrap_target: got %h expected %h", rom_addr, 8'h1A); end
    endtask

    task automatic test_halt();
        wait_valid("wait_halt");
        checks++; if ({I, io_addr} !== 8'h90) begin errors++; $display("[TB] FAIL halt_instr: got %h expected %h", {I, io_addr}, 8'h90); end
        pulse_step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MC14500B_SEQ_HALT_EN
        for (int c = 0; c < 4; c++) begin
            checks++; if ({halted, instr_valid, rom_addr} !== {1'b1, 1'b0, 8'h1A}) begin errors++; $display("[TB] FAIL halt_hold%0d: got %b %b %h expected 1 0 1a", c, halted, instr_valid, rom_addr); end
            step = 1'b1; JMP = 1'b1; RTN = 1'b1; SKP = (c == 2);
            @(negedge clk_in);
        end
        step = 1'b0; JMP = 1'b0; RTN = 1'b0; SKP = 1'b0;
        rst = 1'b1;
        @(negedge clk_in);
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset: got %b expected %b", halted, 1'b0); end
        rst = 1'b0;
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL halt_refetch: got %h expected %h", rom_addr, 8'h00); end
        wait_valid("wait_after_halt");
        checks++; if ({I, io_addr} !== 8'h1A) begin errors++; $display("[TB] FAIL halt_restart: got %h expected %h", {I, io_addr}, 8'h1A); end
`else
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL flgf_halted: got %b expected %b", halted, 1'b0); end
        checks++; if (rom_addr !== 8'h1B) begin errors++; $display("[TB] FAIL flgf_plain: got %h expected %h", rom_addr, 8'h1B); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL flgf_valid: got %b expected %b", instr_valid, 1'b0); end
`endif
    endtask

    task automatic test_reset_mid_jump();
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        wait_valid("wait_mid");
        pulse_step(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (rom_addr !== 8'h01) begin errors++; $display("[TB] FAIL mid_tfetch: got %h expected %h", rom_addr, 8'h01); end
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        checks++; if (dut.sp !== 3'd0) begin errors++; $display("[TB] FAIL mid_no_push: got %0d expected %0d", dut.sp, 0); end
        checks++; if (rom_addr !== 8'h00) begin errors++; $display("[TB] FAIL mid_no_load: got %h expected %h", rom_addr, 8'h00); end
        rst = 1'b0;
        wait_valid("wait_mid_restart");
        checks++; if ({I, io_addr} !== 8'h1A) begin errors++; $display("[TB] FAIL mid_restart: got %h expected %h", {I, io_addr}, 8'h1A); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
        rom[8'h00] = 8'h1A; rom[8'h01] = 8'h51; rom[8'h02] = 8'hC0; rom[8'h03] = 8'h10;
        rom[8'h10] = 8'hC8; rom[8'h11] = 8'h40; rom[8'h40] = 8'h21;
        rom[8'h12] = 8'hC8; rom[8'h13] = 8'h20; rom[8'h20] = 8'hC8; rom[8'h21] = 8'h30;
        rom[8'h30] = 8'hC8; rom[8'h31] = 8'h50; rom[8'h50] = 8'hC8; rom[8'h51] = 8'h60;
        rom[8'h60] = 8'hC8; rom[8'h61] = 8'h70; rom[8'h70] = 8'h2F;
        rom[8'h52] = 8'hFF; rom[8'hFF] = 8'h7E; rom[8'h1A] = 8'h90;
        rst = 1'b1; step = 1'b0; JMP = 1'b0; RTN = 1'b0; SKP = 1'b0; FLGF = 1'b0;
        @(negedge clk_in);
        test_reset();
        test_fetch_issue();
        test_call_return();
        test_nested_calls();
        test_wrap();
        test_halt();
        test_reset_mid_jump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc14500b_seq.md
MC14500B_SEQ -- requirements
Module: mc14500b_seq

Interface
REQ-001 The block SHALL use one clock with a synchronous, active-high reset: clk_in and rst.
REQ-002 The port list SHALL be, in order:
- clk_in  in  1  system clock
- rst  in  1  synchronous active-high reset
- rom_addr  out  8  program ROM address
- rom_data  in  8  ROM word; [7:4] opcode, [3:0] I/O address; valid 1 cycle after rom_addr
- I  out  4  instruction to ICU
- io_addr  out  4  I/O select for ICU data pin
- instr_valid  out  1  I/io_addr hold a current instruction
- step  in  1  1-cycle pulse from ICU: instruction complete
- JMP  in  1  ICU jump flag, sampled at step
- RTN  in  1  ICU return flag, sampled at step
- SKP  in  1  ICU skip active, sampled at step
- FLGF  in  1  ICU NOPF flag, sampled at step
- halted  out  1  sequencer halted
- stack_err  out  1  sticky return-stack overflow/underflow

Function
REQ-003 The block SHALL run six states: FETCH, LATCH, ISSUE, TFETCH, TLATCH, HALT.
REQ-004 FETCH SHALL drive rom_addr=PC for one cycle, then go to LATCH.
REQ-005 LATCH SHALL register rom_data[7:4] into I and rom_data[3:0] into io_addr, then go to ISSUE.
REQ-006 ISSUE SHALL hold instr_valid=1 with I/io_addr stable until step=1.
REQ-007 The latency from entering FETCH to instr_valid=1 SHALL be 2 cycles.
REQ-008 step outside ISSUE SHALL be ignored.
REQ-009 At step in ISSUE, the block SHALL evaluate the following in priority order:
- SKP=1: PC<=PC+1, go to FETCH; the other flags SHALL be ignored.
- RTN=1: PC<=pop, go to FETCH.
- JMP=1: go to TFETCH.
- FLGF=1 with the halt feature compiled in: go to HALT.
- Otherwise: PC<=PC+1, go to FETCH.
REQ-010 instr_valid SHALL deassert in the cycle after step.
REQ-011 TFETCH SHALL drive rom_addr=PC+1.
REQ-012 TLATCH SHALL handle the jump target:
- If io_addr[3]=1 (call), it SHALL push PC+1.
- It SHALL then set PC<=rom_data (8-bit target) and go to FETCH.
- The target byte SHALL never be issued to the ICU in the jump path.
REQ-013 After a return, the popped address is the call's target byte; it SHALL be fetched and issued normally, and the ICU SHALL skip it via SKP.
REQ-014 The return stack SHALL be 4 entries x 8 bits, with a 3-bit pointer sp (0..4).
REQ-015 A push at sp=4 SHALL be discarded and SHALL set stack_err; PC SHALL still load the target.
REQ-016 A pop at sp=0 SHALL load PC<=0x00 and SHALL set stack_err.
REQ-017 PC arithmetic SHALL be modulo 256 (0xFF+1=0x00, including the TFETCH address).
REQ-018 In HALT, the block SHALL hold halted=1, instr_valid=0 and rom_addr constant, and SHALL ignore all inputs until rst.
REQ-019 stack_err SHALL clear only on rst.

Reset
REQ-020 While rst=1 at a clk_in edge, the block SHALL set:
- PC=0x00, sp=0, state=FETCH
- rom_addr=0x00, I=4'b0000 (NOPO), io_addr=0
- instr_valid=0, halted=0, stack_err=0
REQ-021 rst asserted in any state, including mid-jump (TFETCH/TLATCH) or HALT, SHALL abort the operation with no push, PC load or stack update.
REQ-022 The first FETCH SHALL be of address 0x00 in the first cycle after rst deasserts.

Configuration
REQ-023 Macro MC14500B_SEQ_HALT_EN:
- Defined: FLGF=1 at step (SKP=0, RTN=0, JMP=0) SHALL enter HALT.
- Undefined: the HALT state and halted logic SHALL be absent, halted SHALL be tied 0, and FLGF SHALL be treated as a plain instruction (PC+1).

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ROM 0x00=0x1A, 0x01=0x51; release rst, pulse step at each instr_valid -> I/io_addr=1/A then 5/1; rom_addr 0x00,0x01,0x02.
- ROM 0x10=0xC8, 0x11=0x40; at step assert JMP -> rom_addr 0x11 then 0x40; sp=1, stack holds 0x11; target byte never has instr_valid=1.
- At 0x40 step with RTN=1 -> next fetch 0x11; at its step SKP=1 -> next fetch 0x12, no jump.
- Five nested calls (sp reaches 4) -> stack_err=1 after fifth, PC still loads target; RTN at sp=0 -> fetch 0x00, stack_err stays 1.
- PC=0xFF, plain step -> next fetch 0x00; with HALT_EN, step with FLGF=1 -> halted=1, no further rom_addr changes; rst -> halted=0, fetch 0x00.
